// File: rtl/prime_candidate_gen.sv
// Upstream candidate source for the 32-bit primality tester.
// Draws odd full-width LFSR candidates and keeps the first two distinct primes.
module prime_candidate_gen #(
   parameter logic [31:0] SEED      = 32'h0000_0001,
   parameter int          MAX_TRIES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic [31:0] number,
   output logic        start_pt,
   input  logic [31:0] prime_out,
   input  logic        done,
   output logic [31:0] p_out,
   output logic [31:0] q_out,
   output logic        pair_valid,
   output logic        busy,
   output logic        fail,
   output logic [7:0]  tries
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GEN   = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;
   localparam logic [2:0] S_DWAIT = 3'd6;
   localparam logic [2:0] S_FAIL  = 3'd7;

   localparam logic [31:0] MASK      = 32'h8020_0003;
   localparam logic [31:0] FORCE     = 32'h8000_0001;
   localparam logic [7:0]  TRY_LIMIT = 8'(MAX_TRIES);

   logic [2:0]  state;
   logic [31:0] lfsr;
   logic [31:0] lfsr_next;
   logic [31:0] result;
   logic        have_p;
   logic        accepted;

   // Galois right-shift step of the candidate LFSR
   always_comb begin
      lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? MASK : 32'h0);
   end

   // Tester result matches the issued candidate
   always_comb begin
      accepted = (result == number) && (result != 32'h0);
   end

   assign start_pt = (state == S_ISSUE);
   assign busy     = (state != S_IDLE);

   // Candidate sequencing and prime capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         lfsr       <= SEED;
         number     <= 32'h0;
         result     <= 32'h0;
         have_p     <= 1'b0;
         p_out      <= 32'h0;
         q_out      <= 32'h0;
         pair_valid <= 1'b0;
         fail       <= 1'b0;
         tries      <= 8'h0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_GEN;
                  pair_valid <= 1'b0;
                  fail       <= 1'b0;
                  tries      <= 8'h0;
                  have_p     <= 1'b0;
                  p_out      <= 32'h0;
                  q_out      <= 32'h0;
               end
            end
            S_GEN: begin
               if (tries == TRY_LIMIT) begin
                  state <= S_FAIL;
               end else begin
                  lfsr   <= lfsr_next;
                  number <= lfsr_next | FORCE;
                  tries  <= tries + 8'd1;
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (done) begin
                  result <= prime_out;
                  state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (!accepted) begin
                  state <= S_DRAIN;
               end else if (!have_p) begin
                  p_out  <= number;
                  have_p <= 1'b1;
                  tries  <= 8'h0;
                  state  <= S_DRAIN;
               end else if (number == p_out) begin
                  state <= S_DRAIN;
               end else begin
                  q_out      <= number;
                  pair_valid <= 1'b1;
                  state      <= S_DWAIT;
               end
            end
            S_DRAIN: begin
               if (!done) begin
                  state <= S_GEN;
               end
            end
            S_DWAIT: begin
               if (!done) begin
                  state <= S_IDLE;
               end
            end
            S_FAIL: begin
               fail  <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/prime_candidate_gen.md
Name: prime_candidate_gen

Overview:
- Upstream stage of the 32-bit primality tester.
- Draws odd, full-width candidates from an internal LFSR and feeds them one at a time to the tester over its start/done handshake.
- Keeps the first two distinct accepted primes as p and q for the RSA key-setup stage.
- Reports a failure if either prime is not found within a bounded number of candidates.

Parameters:
- SEED, 32'h0000_0001, LFSR reset value. Must be non-zero; zero is illegal.
- MAX_TRIES, 64, maximum candidates tested per prime before failure (1..255).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to generate a (p,q) pair. Ignored while busy.
- number  output  32  candidate driven to the tester. Stable from the start_pt cycle until done is seen.
- start_pt  output  1  one-cycle pulse launching a tester run.
- prime_out  input  32  tester result: the candidate if prime, else 0.
- done  input  1  tester completion level.
- p_out  output  32  first accepted prime.
- q_out  output  32  second accepted prime.
- pair_valid  output  1  high when p_out/q_out are valid. Held until the next accepted start or reset.
- busy  output  1  high in every state except IDLE.
- fail  output  1  set when MAX_TRIES is exhausted. Held until the next accepted start or reset.
- tries  output  8  candidates issued for the prime currently being sought.

Behaviour:
- Reset values (asynchronous, active-low): state=IDLE, lfsr=SEED, and all outputs 0.
- LFSR:
  - 32-bit right-shift Galois, mask 32'h8020_0003.
  - next = (lfsr>>1) ^ (lfsr[0] ? 32'h8020_0003 : 0).
  - Steps only in GEN; never reseeded except by reset, so successive pairs differ.
- Candidate: number <= next | 32'h8000_0001, i.e. MSB and LSB forced.
- Internal flag `have_p` marks that p has been accepted.
- States and transitions:
  - IDLE: on start → GEN. Clear pair_valid, fail, tries, have_p, p_out, q_out.
  - GEN (1 cycle):
    - If tries==MAX_TRIES → FAIL.
    - Otherwise step the LFSR, load number, increment tries, → ISSUE.
  - ISSUE (1 cycle): start_pt=1 → WAIT.
  - WAIT: hold number; on done=1 → CHECK, capturing prime_out into an internal result register. No timeout.
  - CHECK (1 cycle):
    - Candidate is accepted iff result==number && result!=0.
    - Reject → DRAIN.
    - Accept with !have_p → p_out<=number, have_p<=1, tries<=0 → DRAIN.
    - Accept with have_p:
      - If number==p_out → reject, → DRAIN.
      - Otherwise q_out<=number, pair_valid<=1 → DONE_WAIT.
  - DRAIN: wait for done=0, then → GEN. The tester must be back in idle before the next start_pt.
  - DONE_WAIT: wait for done=0, then → IDLE.
  - FAIL (1 cycle): fail<=1 → IDLE. p_out and q_out keep whatever was captured (p may be valid; q is 0).
- start_pt is never asserted outside ISSUE. There is exactly one pulse per candidate.
- done outside WAIT/DRAIN/DONE_WAIT is ignored.
- start in any state other than IDLE is ignored and has no effect on outputs.
- Simultaneous start and reset: reset wins.
- Reset mid-run: immediate return to IDLE with reset values. Any tester run in flight is abandoned.
- Minimum latency start → first start_pt: 2 cycles (start sampled in IDLE; GEN; start_pt in ISSUE).
- tries saturates logically at MAX_TRIES (FAIL is taken before any overflow).

Test Plan:
- Reset with SEED=1 → all outputs 0, busy=0. Pulse start → start_pt on the 2nd following edge with number=32'h8020_0003.
- Tester model accepts every candidate (prime_out=number, done high 1 cycle) → p_out=32'h8020_0003, q_out=second candidate (LFSR step from 32'h8020_0003, OR 32'h8000_0001), pair_valid=1, busy=0, exactly 2 start_pt pulses.
- Model rejects 3 candidates (prime_out=0), then accepts 2 → p_out=4th candidate, q_out=5th, tries=1 at finish, 5 start_pt pulses total.
- MAX_TRIES=4, model always rejects → exactly 4 start_pt pulses, then fail=1, pair_valid=0, p_out=0, busy=0.
- Model holds done high 10 cycles after the first result → no second start_pt until 2 cycles after done falls. start pulsed during WAIT is ignored.
- Reset asserted in WAIT → outputs clear asynchronously, lfsr=SEED. Next start reproduces number=32'h8020_0003.
